xy_resource_ni: RTL and testbench

//  Resource-side network interface for one node of the XY mesh. It sits between a local core
//  and the resource port of that node's xy_switch. TX path: packs core requests into
//  {X,Y,DATA} packets, buffers them and writes them into the switch input FIFO under its full

---
 rtl/xy_resource_ni.sv | 168 ++++++++++++++++
 tb/tb_xy_resource_ni.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/xy_resource_ni.sv
// Resource-side network interface for one XY mesh node: TX FIFO towards the switch
// resource input, RX FIFO from the switch ejection port with overflow/misroute reporting.
module xy_resource_ni #(
  parameter int X_CORD          = 0,
  parameter int Y_CORD          = 0,
  parameter int PCKT_XADDR_W    = 4,
  parameter int PCKT_YADDR_W    = 4,
  parameter int PCKT_DATA_W     = 8,
  parameter int TX_FIFO_DEPTH_W = 2,
  parameter int RX_FIFO_DEPTH_W = 2,
  localparam int PCKT_W = PCKT_XADDR_W + PCKT_YADDR_W + PCKT_DATA_W
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    tx_vld_i,
  output logic                    tx_rdy_o,
  input  logic [PCKT_XADDR_W-1:0] tx_x_addr_i,
  input  logic [PCKT_YADDR_W-1:0] tx_y_addr_i,
  input  logic [PCKT_DATA_W-1:0]  tx_data_i,
  output logic                    sw_wr_en_o,
  output logic [PCKT_W-1:0]       sw_pckt_o,
  input  logic                    sw_in_fifo_full_i,
  input  logic                    sw_wr_en_i,
  input  logic [PCKT_W-1:0]       sw_pckt_i,
  output logic                    rx_fifo_full_o,
  output logic                    rx_fifo_overflow_o,
  output logic                    rx_vld_o,
  input  logic                    rx_rdy_i,
  output logic [PCKT_DATA_W-1:0]  rx_data_o,
  output logic                    misroute_o,
  output logic [15:0]             tx_cnt_o,
  output logic [15:0]             rx_cnt_o
);

  localparam int TX_DEPTH = 2 ** TX_FIFO_DEPTH_W;
  localparam int RX_DEPTH = 2 ** RX_FIFO_DEPTH_W;
  localparam logic [TX_FIFO_DEPTH_W:0] TX_FULL_CNT = (TX_FIFO_DEPTH_W+1)'(TX_DEPTH);
  localparam logic [RX_FIFO_DEPTH_W:0] RX_FULL_CNT = (RX_FIFO_DEPTH_W+1)'(RX_DEPTH);
  localparam logic [PCKT_XADDR_W-1:0] MY_X = PCKT_XADDR_W'(X_CORD);
  localparam logic [PCKT_YADDR_W-1:0] MY_Y = PCKT_YADDR_W'(Y_CORD);

  logic [PCKT_W-1:0]          tx_mem_q [TX_DEPTH];
  logic [PCKT_W-1:0]          tx_mem_d [TX_DEPTH];
  logic [TX_FIFO_DEPTH_W-1:0] tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
  logic [TX_FIFO_DEPTH_W:0]   tx_count_q, tx_count_d;

  logic [PCKT_DATA_W-1:0]     rx_mem_q [RX_DEPTH];
  logic [PCKT_DATA_W-1:0]     rx_mem_d [RX_DEPTH];
  logic [RX_FIFO_DEPTH_W-1:0] rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
  logic [RX_FIFO_DEPTH_W:0]   rx_count_q, rx_count_d;

  logic [15:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic        misroute_q, misroute_d, rx_ovf_q, rx_ovf_d;

  logic tx_full_s, tx_empty_s, tx_push_s, tx_pop_s;
  logic rx_full_s, rx_empty_s, rx_wr_s, rx_pop_s, rx_addr_bad_s;

  assign tx_full_s  = (tx_count_q == TX_FULL_CNT);
  assign tx_empty_s = (tx_count_q == {(TX_FIFO_DEPTH_W+1){1'b0}});
  assign rx_full_s  = (rx_count_q == RX_FULL_CNT);
  assign rx_empty_s = (rx_count_q == {(RX_FIFO_DEPTH_W+1){1'b0}});

  // Reset gating keeps the handshake outputs quiet while rst_i is held.
  assign tx_rdy_o   = !tx_full_s && !rst_i;
  assign sw_wr_en_o = !tx_empty_s && !sw_in_fifo_full_i && !rst_i;
  assign sw_pckt_o  = sw_wr_en_o ? tx_mem_q[tx_rd_ptr_q] : {PCKT_W{1'b0}};
  assign tx_push_s  = tx_vld_i && tx_rdy_o;
  assign tx_pop_s   = sw_wr_en_o;

  assign rx_fifo_full_o     = rx_full_s;
  assign rx_fifo_overflow_o = rx_ovf_q;
  assign rx_vld_o           = !rx_empty_s && !rst_i;
  assign rx_data_o          = rx_mem_q[rx_rd_ptr_q];
  assign rx_wr_s            = sw_wr_en_i && !rx_full_s;
  assign rx_pop_s           = rx_vld_o && rx_rdy_i;
  assign rx_addr_bad_s      = (sw_pckt_i[PCKT_W-1 -: PCKT_XADDR_W] != MY_X) ||
                              (sw_pckt_i[PCKT_DATA_W +: PCKT_YADDR_W] != MY_Y);

  assign misroute_o = misroute_q;
  assign tx_cnt_o   = tx_cnt_q;
  assign rx_cnt_o   = rx_cnt_q;

  // Next-state for both FIFOs, counters and status flags.
  always_comb begin
    tx_mem_d    = tx_mem_q;
    tx_wr_ptr_d = tx_wr_ptr_q;
    tx_rd_ptr_d = tx_rd_ptr_q;
    tx_count_d  = tx_count_q;
    rx_mem_d    = rx_mem_q;
    rx_wr_ptr_d = rx_wr_ptr_q;
    rx_rd_ptr_d = rx_rd_ptr_q;
    rx_count_d  = rx_count_q;
    tx_cnt_d    = tx_cnt_q;
    rx_cnt_d    = rx_cnt_q;
    misroute_d  = misroute_q;
    rx_ovf_d    = sw_wr_en_i && rx_full_s;

    if (tx_push_s) begin
      tx_mem_d[tx_wr_ptr_q] = {tx_x_addr_i, tx_y_addr_i, tx_data_i};
      tx_wr_ptr_d           = tx_wr_ptr_q + 1'b1;
    end else begin
      tx_wr_ptr_d = tx_wr_ptr_q;
    end
    if (tx_pop_s) begin
      tx_rd_ptr_d = tx_rd_ptr_q + 1'b1;
      tx_cnt_d    = tx_cnt_q + 16'd1;
    end else begin
      tx_rd_ptr_d = tx_rd_ptr_q;
    end
    case ({tx_push_s, tx_pop_s})
      2'b10:   tx_count_d = tx_count_q + 1'b1;
      2'b01:   tx_count_d = tx_count_q - 1'b1;
      default: tx_count_d = tx_count_q;
    endcase

    // Misrouted packets are still stored; only the sticky flag records them.
    if (rx_wr_s) begin
      rx_mem_d[rx_wr_ptr_q] = sw_pckt_i[PCKT_DATA_W-1:0];
      rx_wr_ptr_d           = rx_wr_ptr_q + 1'b1;
      rx_cnt_d              = rx_cnt_q + 16'd1;
      misroute_d            = misroute_q || rx_addr_bad_s;
    end else begin
      rx_wr_ptr_d = rx_wr_ptr_q;
    end
    if (rx_pop_s) begin
      rx_rd_ptr_d = rx_rd_ptr_q + 1'b1;
    end else begin
      rx_rd_ptr_d = rx_rd_ptr_q;
    end
    case ({rx_wr_s, rx_pop_s})
      2'b10:   rx_count_d = rx_count_q + 1'b1;
      2'b01:   rx_count_d = rx_count_q - 1'b1;
      default: rx_count_d = rx_count_q;
    endcase
  end

  // State registers; reset empties both FIFOs and clears all status.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < TX_DEPTH; i++) tx_mem_q[i] <= {PCKT_W{1'b0}};
      for (int i = 0; i < RX_DEPTH; i++) rx_mem_q[i] <= {PCKT_DATA_W{1'b0}};
      tx_wr_ptr_q <= {TX_FIFO_DEPTH_W{1'b0}};
      tx_rd_ptr_q <= {TX_FIFO_DEPTH_W{1'b0}};
      tx_count_q  <= {(TX_FIFO_DEPTH_W+1){1'b0}};
      rx_wr_ptr_q <= {RX_FIFO_DEPTH_W{1'b0}};
      rx_rd_ptr_q <= {RX_FIFO_DEPTH_W{1'b0}};
      rx_count_q  <= {(RX_FIFO_DEPTH_W+1){1'b0}};
      tx_cnt_q    <= 16'd0;
      rx_cnt_q    <= 16'd0;
      misroute_q  <= 1'b0;
      rx_ovf_q    <= 1'b0;
    end else begin
      tx_mem_q    <= tx_mem_d;
      rx_mem_q    <= rx_mem_d;
      tx_wr_ptr_q <= tx_wr_ptr_d;
      tx_rd_ptr_q <= tx_rd_ptr_d;
      tx_count_q  <= tx_count_d;
      rx_wr_ptr_q <= rx_wr_ptr_d;
      rx_rd_ptr_q <= rx_rd_ptr_d;
      rx_count_q  <= rx_count_d;
      tx_cnt_q    <= tx_cnt_d;
      rx_cnt_q    <= rx_cnt_d;
      misroute_q  <= misroute_d;
      rx_ovf_q    <= rx_ovf_d;
    end
  end

endmodule

// File: tb/tb_xy_resource_ni.sv
// Self-checking bench for xy_resource_ni at node (1,2): directed stimulus, queue-based
// scoreboard for TX packets and RX payloads, plus directed status checks.
module tb_xy_resource_ni;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        tx_vld_i = 1'b0;
  logic        tx_rdy_o;
  logic [3:0]  tx_x_addr_i = 4'h0;
  logic [3:0]  tx_y_addr_i = 4'h0;
  logic [7:0]  tx_data_i = 8'h00;
  logic        sw_wr_en_o;
  logic [15:0] sw_pckt_o;
  logic        sw_in_fifo_full_i = 1'b0;
  logic        sw_wr_en_i = 1'b0;
  logic [15:0] sw_pckt_i = 16'h0000;
  logic        rx_fifo_full_o;
  logic        rx_fifo_overflow_o;
  logic        rx_vld_o;
  logic        rx_rdy_i = 1'b0;
  logic [7:0]  rx_data_o;
  logic        misroute_o;
  logic [15:0] tx_cnt_o;
  logic [15:0] rx_cnt_o;

  int total = 0;
  int bad   = 0;
  logic [15:0] tx_q[$];
  logic [7:0]  rx_q[$];

  xy_resource_ni #(.X_CORD(1), .Y_CORD(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .tx_vld_i(tx_vld_i), .tx_rdy_o(tx_rdy_o),
    .tx_x_addr_i(tx_x_addr_i), .tx_y_addr_i(tx_y_addr_i), .tx_data_i(tx_data_i),
    .sw_wr_en_o(sw_wr_en_o), .sw_pckt_o(sw_pckt_o), .sw_in_fifo_full_i(sw_in_fifo_full_i),
    .sw_wr_en_i(sw_wr_en_i), .sw_pckt_i(sw_pckt_i),
    .rx_fifo_full_o(rx_fifo_full_o), .rx_fifo_overflow_o(rx_fifo_overflow_o),
    .rx_vld_o(rx_vld_o), .rx_rdy_i(rx_rdy_i), .rx_data_o(rx_data_o),
    .misroute_o(misroute_o), .tx_cnt_o(tx_cnt_o), .rx_cnt_o(rx_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic samp();
    @(negedge clk_i);
  endtask

  // Scoreboard monitor: compares every packet leaving towards the switch and every RX pop.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (sw_wr_en_o) begin
        if (tx_q.size() == 0) check("tx_unexpected", 32'(sw_pckt_o), 32'hFFFF_FFFF);
        else check("tx_pckt", 32'(sw_pckt_o), 32'(tx_q.pop_front()));
      end
      if (rx_vld_o && rx_rdy_i) begin
        if (rx_q.size() == 0) check("rx_unexpected", 32'(rx_data_o), 32'hFFFF_FFFF);
        else check("rx_data", 32'(rx_data_o), 32'(rx_q.pop_front()));
      end
    end
  end

  initial begin
    // Reset values
    samp();
    check("rst_tx_rdy", 32'(tx_rdy_o), 32'd0);
    check("rst_sw_wr_en", 32'(sw_wr_en_o), 32'd0);
    check("rst_sw_pckt", 32'(sw_pckt_o), 32'd0);
    check("rst_rx_vld", 32'(rx_vld_o), 32'd0);
    check("rst_rx_full", 32'(rx_fifo_full_o), 32'd0);
    check("rst_ovf", 32'(rx_fifo_overflow_o), 32'd0);
    check("rst_misroute", 32'(misroute_o), 32'd0);
    check("rst_cnts", {tx_cnt_o, rx_cnt_o}, 32'd0);
    tick();
    rst_i = 1'b0;
    samp();
    check("post_rst_tx_rdy", 32'(tx_rdy_o), 32'd1);
    tick();

    // 1: single packet to (3,1)
    tx_vld_i = 1'b1; tx_x_addr_i = 4'h3; tx_y_addr_i = 4'h1; tx_data_i = 8'hA5;
    tx_q.push_back(16'h31A5);
    samp();
    check("t1_no_bypass", 32'(sw_wr_en_o), 32'd0);
    tick();
    tx_vld_i = 1'b0;
    samp();
    check("t1_wr_en", 32'(sw_wr_en_o), 32'd1);
    check("t1_pckt", 32'(sw_pckt_o), 32'h31A5);
    tick();
    samp();
    check("t1_tx_cnt", 32'(tx_cnt_o), 32'd1);
    check("t1_wr_en_low", 32'(sw_wr_en_o), 32'd0);
    tick();

    // 2: switch full, fill the TX FIFO, 5th request refused
    sw_in_fifo_full_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tx_vld_i = 1'b1; tx_x_addr_i = 4'(i); tx_y_addr_i = 4'(i + 4); tx_data_i = 8'(8'hC0 + i);
      tx_q.push_back({4'(i), 4'(i + 4), 8'(8'hC0 + i)});
      tick();
    end
    samp();
    check("t2_tx_rdy_full", 32'(tx_rdy_o), 32'd0);
    check("t2_wr_en_blocked", 32'(sw_wr_en_o), 32'd0);
    tx_x_addr_i = 4'h9; tx_y_addr_i = 4'h9; tx_data_i = 8'h99;
    tick();
    samp();
    check("t2_still_full", 32'(tx_rdy_o), 32'd0);
    tick();
    tx_vld_i = 1'b0;
    sw_in_fifo_full_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      samp();
      check("t2_drain_wr_en", 32'(sw_wr_en_o), 32'd1);
      tick();
    end
    samp();
    check("t2_drain_done", 32'(sw_wr_en_o), 32'd0);
    check("t2_tx_cnt", 32'(tx_cnt_o), 32'd5);
    tick();

    // 3: RX fill with core stalled, then overflow (also while the core pops)
    for (int i = 0; i < 4; i++) begin
      sw_wr_en_i = 1'b1; sw_pckt_i = {4'h1, 4'h2, 8'(8'h10 + i)};
      rx_q.push_back(8'(8'h10 + i));
      if (i == 0) begin
        samp();
        check("t3_rx_no_bypass", 32'(rx_vld_o), 32'd0);
      end
      tick();
    end
    sw_wr_en_i = 1'b0;
    samp();
    check("t3_rx_full", 32'(rx_fifo_full_o), 32'd1);
    check("t3_rx_head", 32'(rx_data_o), 32'h10);
    tick();
    sw_wr_en_i = 1'b1; sw_pckt_i = 16'h1214;
    tick();
    sw_wr_en_i = 1'b0;
    samp();
    check("t3_ovf_pulse", 32'(rx_fifo_overflow_o), 32'd1);
    check("t3_rx_cnt", 32'(rx_cnt_o), 32'd4);
    tick();
    samp();
    check("t3_ovf_one_cycle", 32'(rx_fifo_overflow_o), 32'd0);
    tick();
    sw_wr_en_i = 1'b1; sw_pckt_i = 16'h1215; rx_rdy_i = 1'b1;
    tick();
    sw_wr_en_i = 1'b0; rx_rdy_i = 1'b0;
    samp();
    check("t3_ovf_with_pop", 32'(rx_fifo_overflow_o), 32'd1);
    check("t3_full_after_pop", 32'(rx_fifo_full_o), 32'd0);
    check("t3_rx_cnt_keep", 32'(rx_cnt_o), 32'd4);
    tick();
    rx_rdy_i = 1'b1;
    repeat (6) tick();
    rx_rdy_i = 1'b0;
    samp();
    check("t3_drained", 32'(rx_vld_o), 32'd0);
    check("t3_no_misroute", 32'(misroute_o), 32'd0);
    tick();

    // 4: misrouted packet still delivered
    sw_wr_en_i = 1'b1; sw_pckt_i = 16'h4577;
    rx_q.push_back(8'h77);
    tick();
    sw_wr_en_i = 1'b0;
    samp();
    check("t4_misroute", 32'(misroute_o), 32'd1);
    check("t4_rx_vld", 32'(rx_vld_o), 32'd1);
    check("t4_rx_data", 32'(rx_data_o), 32'h77);
    tick();
    rx_rdy_i = 1'b1;
    tick();
    rx_rdy_i = 1'b0;
    repeat (3) tick();
    samp();
    check("t4_sticky", 32'(misroute_o), 32'd1);
    check("t4_empty", 32'(rx_vld_o), 32'd0);
    check("t4_rx_cnt", 32'(rx_cnt_o), 32'd5);
    tick();

    // 5: asynchronous reset with both FIFOs partly filled
    sw_in_fifo_full_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tx_vld_i = 1'b1; tx_x_addr_i = 4'h7; tx_y_addr_i = 4'h7; tx_data_i = 8'(i);
      sw_wr_en_i = 1'b1; sw_pckt_i = {4'h1, 4'h2, 8'(8'h50 + i)};
      tick();
    end
    tx_vld_i = 1'b0; sw_wr_en_i = 1'b0;
    samp();
    check("t5_pre_rx_vld", 32'(rx_vld_o), 32'd1);
    tick();
    rst_i = 1'b1;
    #1;
    check("t5_tx_rdy", 32'(tx_rdy_o), 32'd0);
    check("t5_sw_wr_en", 32'(sw_wr_en_o), 32'd0);
    check("t5_sw_pckt", 32'(sw_pckt_o), 32'd0);
    check("t5_rx_vld", 32'(rx_vld_o), 32'd0);
    check("t5_rx_full", 32'(rx_fifo_full_o), 32'd0);
    check("t5_misroute", 32'(misroute_o), 32'd0);
    check("t5_cnts", {tx_cnt_o, rx_cnt_o}, 32'd0);
    sw_in_fifo_full_i = 1'b0;
    tick();
    tick();
    rst_i = 1'b0;
    samp();
    check("t5_rel_tx_rdy", 32'(tx_rdy_o), 32'd1);
    check("t5_rel_rx_vld", 32'(rx_vld_o), 32'd0);
    check("t5_rel_wr_en", 32'(sw_wr_en_o), 32'd0);
    tick();

    // 6: tx_cnt wrap after 65536 sends
    for (int i = 0; i < 65535; i++) begin
      tx_vld_i = 1'b1; tx_x_addr_i = 4'(i >> 12); tx_y_addr_i = 4'(i >> 8); tx_data_i = 8'(i);
      tx_q.push_back(16'(i));
      tick();
    end
    tx_vld_i = 1'b0;
    repeat (3) tick();
    samp();
    check("t6_cnt_ffff", 32'(tx_cnt_o), 32'h0000FFFF);
    tick();
    tx_vld_i = 1'b1; tx_x_addr_i = 4'hE; tx_y_addr_i = 4'hD; tx_data_i = 8'h42;
    tx_q.push_back(16'hED42);
    tick();
    tx_vld_i = 1'b0;
    repeat (3) tick();
    samp();
    check("t6_cnt_wrap", 32'(tx_cnt_o), 32'd0);

    check("tx_queue_empty", 32'(tx_q.size()), 32'd0);
    check("rx_queue_empty", 32'(rx_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
